serial_cra_adder: RTL
=====================

// Module: serial_cra_adder
// PURPOSE
//   Parametrised digit-serial ripple-carry adder/subtractor for the CRA family.
//   Adds two WIDTH-bit operands DIGIT bits per clock, with a registered carry between digits.
//   Carry-in is selectable: from the cin port, forced 1, forced 0, or subtract (b inverted, cin=1).
//   Used where area matters more than latency; start/busy/done handshake to the controlling FSM.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
//   DIGIT  4   bits processed per cycle; 1..WIDTH; N = WIDTH/DIGIT cycles per operation
// PORTS
//   clk    in   1      single clock; all state updates on the rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only in IDLE or DONE
//   a      in   WIDTH  operand A; captured on accepted start
//   b      in   WIDTH  operand B; captured on accepted start
//   cin    in   1      carry-in; used only when mode=00; captured on accepted start
//   mode   in   2      00 a+b+cin, 01 a+b+1, 10 a-b (a+~b+1), 11 a+b+0; captured on start
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; result valid
//   s      out  WIDTH  sum/difference; held from done until the next accepted start
//   cout   out  1      carry out of the MSB; in subtract mode 1 = no borrow (a >= b unsigned)
//   ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset: FSM=IDLE; s=0, cout=0, ovf=0, busy=0, done=0; the operand/carry registers are cleared.
//   - FSM states IDLE, RUN, DONE:
//     IDLE: start=1 -> capture a, b (b inverted if mode=10) and effective carry -> RUN, digit count=0.
//     RUN: on each cycle, add the low DIGIT bits of the A and B shift registers plus the carry register.
//       Shift the sum digit into the result register from the MSB side.
//       Shift the A/B registers right by DIGIT.
//       Update the carry register; increment the count.
//       On the cycle that processes the last digit (count=N-1): latch cout.
//       On that cycle, also latch ovf from the MSB-bit carries -> DONE.
//     DONE: done=1 for exactly one cycle; s/cout/ovf are stable.
//       start=1 here is accepted (back-to-back) -> RUN; otherwise -> IDLE.
//   - Latency: start accepted at edge k.
//     Digits are processed at edges k+1..k+N; DONE is entered at edge k+N.
//     done is high in the cycle between edges k+N and k+N+1.
//     Throughput with back-to-back start: one result per N+1 cycles.
//   - busy=1 exactly in RUN (N cycles); busy and done are never high together.
//   - start in RUN: ignored; the operation in flight is unaffected; a, b, cin, mode are don't-care.
//   - s during RUN: partial/shifting value, not valid. s, cout, ovf hold from DONE until the next RUN begins.
//   - Effective carry: mode 00 -> cin; mode 01 -> 1; mode 10 -> 1; mode 11 -> 0.
//   - Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of the full-precision sum.
//   - DIGIT=WIDTH: N=1 (one RUN cycle). DIGIT=1: N=WIDTH (bit-serial).
//   - rst mid-RUN or in DONE: reset values on the next edge; no done pulse; next start starts cleanly.
//   - rst and start asserted together: rst wins; start is not accepted.
//   - The count register width is clog2(N) with a minimum of 1; it wraps only via FSM exit, never free-running.
// TESTING (WIDTH=16, DIGIT=4 unless noted)
//   1 mode=01, a=0x0000, b=0x0000, start 1 cycle -> busy 4 cycles, then done pulse.
//     s=0x0001, cout=0, ovf=0.
//   2 mode=00, cin=1, a=0xFFFF, b=0x0000 -> s=0x0000, cout=1, ovf=0.
//     mode=11, a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
//   3 mode=10, a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0.
//     mode=10, a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
//   4 start re-pulsed with new operands during RUN -> ignored; the first result is unchanged.
//     rst in the 2nd RUN cycle -> all outputs 0 next cycle, no done.
//     The following start gives the correct result.
//   5 start held high continuously -> done every 5 cycles, each with the correct result; s stable on done.
//   6 Random self-checking (10k ops, all modes) vs a+b+carry reference, rerun at DIGIT=1, 16, and 8.

Source files
------------

// File: rtl/serial_cra_adder.sv
// Digit-serial ripple-carry adder/subtractor: adds two WIDTH-bit operands DIGIT bits per cycle
// with a registered inter-digit carry, under a start/busy/done handshake.
module serial_cra_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT:0]   dsum;
    logic [WIDTH-1:0] dig_ext;
    logic             msb_cin;
    logic             accept;
    logic             last;

    always_comb begin
        dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        dig_ext = '0;
        dig_ext[DIGIT-1:0] = dsum[DIGIT-1:0];
        // Carry into the top bit of this digit, recovered from the sum bit.
        msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
        accept  = start && (state_q != StRun);
        last    = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    a_d = a;
                    b_d = (mode == 2'b10) ? ~b : b;
                    unique case (mode)
                        2'b00:   carry_d = cin;
                        2'b01:   carry_d = 1'b1;
                        2'b10:   carry_d = 1'b1;
                        default: carry_d = 1'b0;
                    endcase
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                s_d     = (s_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (last) begin
                    cout_d  = dsum[DIGIT];
                    ovf_d   = msb_cin ^ dsum[DIGIT];
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
